sdram_device_responder: RTL
===========================

Name: sdram_device_responder

Overview:
- Synthesizable responder for the SDR SDRAM command/data bus. It acts as the memory-chip end of the bus driven by sdram_controller.
- Used in simulation and in on-FPGA loopback builds in place of the physical SDRAM.
- Decodes CS/RAS/CAS/WE commands, tracks the mode register and open rows per bank, stores write data in internal RAM and returns read data at the programmed CAS latency.
- Sticky protocol-error flags let benches and debug logic catch controller sequencing faults.

Parameters:
- MEM_ADDR_W, 10, internal storage index width (2^MEM_ADDR_W 16-bit words). Index is the low MEM_ADDR_W bits of {bank[1:0], row[11:0], col[7:0]}; higher-order addresses alias.
- INIT_REFRESHES, 2, number of REFRESH commands required after PRECHARGE-all before LOAD MODE counts as a valid init.

Ports:
- i_clk  input  1  clock; same clock the controller forwards on its SDRAM clock pin.
- i_rst_n  input  1  asynchronous reset, active low.
- i_SDRAM_CKE  input  1  clock enable; low = command ignored, read pipeline frozen.
- i_SDRAM_CS  input  1  chip select, active low.
- i_SDRAM_RAS  input  1  active low.
- i_SDRAM_CAS  input  1  active low.
- i_SDRAM_WE  input  1  active low.
- i_SDRAM_B0  input  1  bank bit 0.
- i_SDRAM_B1  input  1  bank bit 1.
- i_SDRAM_DQML  input  1  low-byte mask, high = masked.
- i_SDRAM_DQMH  input  1  high-byte mask.
- i_SDRAM_ADR  input  12  row (ACTIVE), column in [7:0] (READ/WRITE), A10 = all-banks (PRECHARGE), mode value (LOAD MODE).
- io_SDRAM_DATA  inout  16  data; driven only during read data cycles, else Z.
- o_init_done  output  1  valid init sequence completed.
- o_cas_latency  output  3  mode register A[6:4].
- o_refresh_cnt  output  16  REFRESH commands seen, saturating at 16'hFFFF.
- o_err  output  4  sticky: [0] READ/WRITE to closed bank, [1] ACTIVE to already-open bank, [2] REFRESH with any bank open, [3] unsupported mode (burst length != 1 or CL not 2/3).

Behaviour:
- Reset (async, i_rst_n low):
  - All outputs 0; io_SDRAM_DATA = Z.
  - All banks closed, mode register = 0, read pipeline empty, init tracker at start.
  - RAM contents are not cleared.
- Command decode, sampled at posedge when CKE = 1. Pattern is {CS, RAS, CAS, WE}:
  - 1xxx = DESELECT.
  - 0111 = NOP.
  - 0011 = ACTIVE.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0010 = PRECHARGE.
  - 0001 = REFRESH.
  - 0000 = LOAD MODE.
  - DESELECT and NOP: no state change.
- ACTIVE: open_row[bank] <= ADR, open[bank] <= 1. If the bank is already open, set err[1] and overwrite the row.
- PRECHARGE: A10 = 1 closes all banks; otherwise closes the addressed bank only.
- REFRESH: o_refresh_cnt increments. If any bank is open, set err[2].
- LOAD MODE:
  - mode <= ADR.
  - Set err[3] if ADR[2:0] != 0 or ADR[6:4] not in {2, 3}.
  - Allowed with banks open, but then o_init_done is not set.
- Init tracker:
  - PRECHARGE-all arms the tracker and clears the refresh tally.
  - After >= INIT_REFRESHES REFRESH commands, a LOAD MODE with all banks closed sets o_init_done = 1. It then stays 1 until reset.
- WRITE:
  - Target word = {bank, open_row[bank], ADR[7:0]}.
  - Low byte written when DQML = 0, high byte when DQMH = 0. Data is io_SDRAM_DATA sampled on the same edge as the command.
  - To a closed bank: no write, set err[0].
- READ:
  - Pushes {valid, index, DQML, DQMH} into the latency pipeline.
  - To a closed bank: push invalid, set err[0].
- Read timing: READ sampled at edge t0.
  - Data is driven from just after edge t0 + CL - 1 through edge t0 + CL, then released to Z.
  - The controller samples the word at edge t0 + CL. CL = 2 gives a 2-cycle gap, CL = 3 a 3-cycle gap.
  - Masked bytes are driven as 8'h00.
  - Back-to-back READs produce consecutive data cycles.
- READ-after-WRITE to the same word returns the new data. RAM read happens at pipeline launch, after a write on an earlier edge.
- CKE = 0: the command is ignored, the pipeline holds, the current drive state holds.
- Unsupported CL (mode not 2/3): treated as CL = 2 for timing; err[3] is already set.
- Reset mid-read: the pipeline clears and the bus goes Z immediately (asynchronous).
- Simultaneous events: only one command per edge exists. Pipeline advance and new READ push occur on the same edge without loss.

Test Plan:
- Controller-style init (NOP, PRECHARGE ADR=12'hFFF, REFRESH x2, LOAD MODE ADR=12'h020) -> o_init_done = 1, o_cas_latency = 2, o_refresh_cnt = 2, o_err = 0.
- After init: ACTIVE bank 1 row 12'h0A5, WRITE col 8'h3C data 16'h00C7 with DQML=0/DQMH=0, PRECHARGE-all, ACTIVE same row, READ col 8'h3C -> io_SDRAM_DATA = 16'h00C7 exactly at edge t0+2, Z on the cycles before and after.
- LOAD MODE ADR=12'h030 (CL = 3), repeat the read -> data at t0+3. Back-to-back READs at cols 1 and 2 -> two consecutive data cycles in order.
- WRITE 16'hBEEF then WRITE 16'h1234 with DQMH=1, read back -> 16'hBE34. READ with DQML=1 -> low byte driven 8'h00.
- READ to a closed bank -> err[0] = 1, bus stays Z. ACTIVE twice on bank 2 -> err[1]. REFRESH with bank 2 open -> err[2]. LOAD MODE ADR=12'h001 -> err[3]. Flags stay set until reset.
- Assert i_rst_n = 0 one cycle after a READ -> bus Z immediately, outputs 0. After release, previously written data is still readable.

Source files
------------

// File: rtl/sdram_device_responder.sv
// ---------------------------------------------------------------------------
// sdram_device_responder
//
// Behavioural-but-synthesizable stand-in for an SDR SDRAM chip. It sits on
// the command/data bus driven by sdram_controller and answers like the real
// part. It is used in simulation and in on-FPGA loopback builds.
//
// What it does:
//   - decodes CS/RAS/CAS/WE commands
//   - tracks the CAS latency from the mode register and the open row per bank
//   - stores write data in an internal RAM
//   - returns read data at the programmed CAS latency
//   - raises sticky error flags when the controller breaks sequencing rules
//
// Ports:
//   i_clk, i_rst_n        clock and asynchronous active-low reset
//   i_SDRAM_CKE           clock enable; low freezes commands and the read pipe
//   i_SDRAM_CS/RAS/CAS/WE active-low command strobes
//   i_SDRAM_B0/B1         bank select
//   i_SDRAM_DQML/DQMH     byte masks (high = masked)
//   i_SDRAM_ADR           row / column / A10 / mode value, by command
//   io_SDRAM_DATA         data bus, driven only during read data cycles
//   o_init_done           a valid PRECHARGE-all / REFRESH / LOAD MODE sequence
//                         has been seen
//   o_cas_latency         mode register bits A[6:4]
//   o_refresh_cnt         saturating count of REFRESH commands
//   o_err                 sticky flags:
//                           [0] READ/WRITE to a closed bank
//                           [1] ACTIVE to an already-open bank
//                           [2] REFRESH while any bank is open
//                           [3] unsupported mode value
// ---------------------------------------------------------------------------
module sdram_device_responder #(
  parameter int MEM_ADDR_W     = 10,
  parameter int INIT_REFRESHES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_SDRAM_CKE,
  input  logic        i_SDRAM_CS,
  input  logic        i_SDRAM_RAS,
  input  logic        i_SDRAM_CAS,
  input  logic        i_SDRAM_WE,
  input  logic        i_SDRAM_B0,
  input  logic        i_SDRAM_B1,
  input  logic        i_SDRAM_DQML,
  input  logic        i_SDRAM_DQMH,
  input  logic [11:0] i_SDRAM_ADR,
  inout  wire  [15:0] io_SDRAM_DATA,
  output logic        o_init_done,
  output logic [2:0]  o_cas_latency,
  output logic [15:0] o_refresh_cnt,
  output logic [3:0]  o_err
);

  // {CS, RAS, CAS, WE} encodings. DESELECT (CS high) is handled separately.
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111
  } cmd_e;

  typedef enum logic [1:0] {
    INIT_IDLE,
    INIT_ARMED,
    INIT_DONE
  } init_e;

  // One slot of the read latency pipeline.
  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] idx;
    logic                  dqml;
    logic                  dqmh;
  } rd_req_t;

  logic [15:0] mem [0:(1 << MEM_ADDR_W) - 1];

  logic [3:0]  bank_open_q, bank_open_d;
  logic [11:0] open_row_q [4];
  logic [11:0] open_row_d [4];
  logic [2:0]  cl_q, cl_d;
  logic [3:0]  err_q, err_d;
  logic [15:0] refresh_cnt_q, refresh_cnt_d;
  logic [15:0] init_tally_q, init_tally_d;
  init_e       init_state_q, init_state_d;
  logic        init_done_q, init_done_d;
  rd_req_t     rd_pipe0_q, rd_pipe0_d;
  rd_req_t     rd_pipe1_q, rd_pipe1_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;

  logic [3:0]            cmd;
  logic [1:0]            bank;
  logic [MEM_ADDR_W-1:0] cmd_idx;
  rd_req_t               launch;
  logic [15:0]           rd_word;
  logic                  wr_lo_en;
  logic                  wr_hi_en;
  logic [MEM_ADDR_W-1:0] wr_idx;
  logic [15:0]           wr_data;

  assign cmd  = {i_SDRAM_CS, i_SDRAM_RAS, i_SDRAM_CAS, i_SDRAM_WE};
  assign bank = {i_SDRAM_B1, i_SDRAM_B0};

  // The storage index keeps only the low bits of {bank, row, col}, so larger
  // address spaces alias onto the small internal RAM.
  assign cmd_idx = MEM_ADDR_W'({bank, open_row_q[bank], i_SDRAM_ADR[7:0]});

  // A READ is launched onto the bus at edge t0+CL-1. CL=3 launches from the
  // second pipe slot and anything else from the first. Unsupported latencies
  // therefore behave as CL=2.
  assign launch  = (cl_q == 3'd3) ? rd_pipe1_q : rd_pipe0_q;
  assign rd_word = mem[launch.idx];

  always_comb begin
    bank_open_d   = bank_open_q;
    open_row_d    = open_row_q;
    cl_d          = cl_q;
    err_d         = err_q;
    refresh_cnt_d = refresh_cnt_q;
    init_tally_d  = init_tally_q;
    init_state_d  = init_state_q;
    rd_pipe0_d    = rd_pipe0_q;
    rd_pipe1_d    = rd_pipe1_q;
    dq_out_d      = dq_out_q;
    dq_oe_d       = dq_oe_q;
    wr_lo_en      = 1'b0;
    wr_hi_en      = 1'b0;
    wr_idx        = cmd_idx;
    wr_data       = io_SDRAM_DATA;

    if (i_SDRAM_CKE) begin
      // Pipeline advance and bus update happen every enabled edge. A new
      // READ on the same edge simply refills slot 0.
      rd_pipe1_d = rd_pipe0_q;
      rd_pipe0_d = '0;
      dq_oe_d    = launch.valid;
      dq_out_d   = '0;
      if (launch.valid) begin
        dq_out_d[7:0]  = launch.dqml ? 8'h00 : rd_word[7:0];
        dq_out_d[15:8] = launch.dqmh ? 8'h00 : rd_word[15:8];
      end

      if (!i_SDRAM_CS) begin
        case (cmd)
          CMD_ACTIVE: begin
            if (bank_open_q[bank]) err_d[1] = 1'b1;
            bank_open_d[bank] = 1'b1;
            open_row_d[bank]  = i_SDRAM_ADR;
          end
          CMD_READ: begin
            if (bank_open_q[bank]) begin
              rd_pipe0_d.valid = 1'b1;
              rd_pipe0_d.idx   = cmd_idx;
              rd_pipe0_d.dqml  = i_SDRAM_DQML;
              rd_pipe0_d.dqmh  = i_SDRAM_DQMH;
            end else begin
              err_d[0] = 1'b1;
            end
          end
          CMD_WRITE: begin
            if (bank_open_q[bank]) begin
              wr_lo_en = !i_SDRAM_DQML;
              wr_hi_en = !i_SDRAM_DQMH;
            end else begin
              err_d[0] = 1'b1;
            end
          end
          CMD_PRECHARGE: begin
            if (i_SDRAM_ADR[10]) begin
              bank_open_d  = '0;
              init_tally_d = '0;
              if (init_state_q != INIT_DONE) init_state_d = INIT_ARMED;
            end else begin
              bank_open_d[bank] = 1'b0;
            end
          end
          CMD_REFRESH: begin
            if (refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
            if (init_tally_q != 16'hFFFF) init_tally_d = init_tally_q + 16'd1;
            if (|bank_open_q) err_d[2] = 1'b1;
          end
          CMD_LOAD_MODE: begin
            cl_d = i_SDRAM_ADR[6:4];
            if (i_SDRAM_ADR[2:0] != 3'b000 ||
                (i_SDRAM_ADR[6:4] != 3'd2 && i_SDRAM_ADR[6:4] != 3'd3))
              err_d[3] = 1'b1;
            // LOAD MODE with a bank open is legal but does not finish init.
            if (init_state_q == INIT_ARMED &&
                init_tally_q >= 16'(INIT_REFRESHES) &&
                bank_open_q == 4'b0000)
              init_state_d = INIT_DONE;
          end
          default: ;
        endcase
      end
    end

    init_done_d = (init_state_d == INIT_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_open_q   <= '0;
      open_row_q    <= '{default: '0};
      cl_q          <= '0;
      err_q         <= '0;
      refresh_cnt_q <= '0;
      init_tally_q  <= '0;
      init_state_q  <= INIT_IDLE;
      init_done_q   <= 1'b0;
      rd_pipe0_q    <= '0;
      rd_pipe1_q    <= '0;
      dq_out_q      <= '0;
      dq_oe_q       <= 1'b0;
    end else begin
      bank_open_q   <= bank_open_d;
      open_row_q    <= open_row_d;
      cl_q          <= cl_d;
      err_q         <= err_d;
      refresh_cnt_q <= refresh_cnt_d;
      init_tally_q  <= init_tally_d;
      init_state_q  <= init_state_d;
      init_done_q   <= init_done_d;
      rd_pipe0_q    <= rd_pipe0_d;
      rd_pipe1_q    <= rd_pipe1_d;
      dq_out_q      <= dq_out_d;
      dq_oe_q       <= dq_oe_d;
    end
  end

  // Storage is deliberately not reset so data survives a controller reset.
  always_ff @(posedge i_clk) begin
    if (wr_lo_en) mem[wr_idx][7:0]  <= wr_data[7:0];
    if (wr_hi_en) mem[wr_idx][15:8] <= wr_data[15:8];
  end

  assign io_SDRAM_DATA = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_init_done   = init_done_q;
  assign o_cas_latency = cl_q;
  assign o_refresh_cnt = refresh_cnt_q;
  assign o_err         = err_q;

endmodule
